// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N_CH producer channels, the stream mux and its single consumer.
// The master modport is the side that drives the producer and consumer stimulus.
interface stream_mux_rr_if #(
    parameter int N_CH = 4,
    parameter int W    = 4
);
    localparam int SELW = $clog2(N_CH);

    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [N_CH*W-1:0] in_data;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_ch;

    modport master (
        output in_valid, in_data, mode, sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, mode, sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Arbitration is round-robin (mode=0) or a fixed channel chosen by sel (mode=1).
module stream_mux_rr #(
    parameter int N_CH = 4,
    parameter int W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int SELW = $clog2(N_CH);

    logic            held_valid;
    logic [W-1:0]    held_data;
    logic [SELW-1:0] held_ch;
    logic [SELW-1:0] last_grant;

    logic            load;
    logic            grant_valid;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] cand;
    logic [W-1:0]    grant_data;
    logic [N_CH-1:0] ready;

    // Arbitration runs only when the output register can accept a beat; reset blocks any grant.
    always_comb begin
        load        = !held_valid || bus.out_ready;
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        if (load && !rst) begin
            if (bus.mode) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (int'(bus.sel) == i && bus.in_valid[i]) begin
                        grant_valid = 1'b1;
                        grant       = SELW'(i);
                    end
                end
            end else begin
                for (int k = 1; k <= N_CH; k++) begin
                    cand = SELW'((int'(last_grant) + k) % N_CH);
                    if (!grant_valid && bus.in_valid[cand]) begin
                        grant_valid = 1'b1;
                        grant       = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        ready      = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = bus.in_data[i*W +: W];
            end
            ready[i] = grant_valid && (grant == SELW'(i));
        end
    end

    // A load with no grant drains the register; data and channel keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_valid <= 1'b0;
            held_data  <= '0;
            held_ch    <= '0;
            last_grant <= SELW'(N_CH - 1);
        end else if (load) begin
            if (grant_valid) begin
                held_valid <= 1'b1;
                held_data  <= grant_data;
                held_ch    <= grant;
                last_grant <= grant;
            end else begin
                held_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = held_valid;
    assign bus.out_data  = held_data;
    assign bus.out_ch    = held_ch;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus random traffic against a beat-level model.
// A second 3-channel instance covers the out-of-range select case.
module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.N_CH(4), .W(4)) bus ();
    stream_mux_rr_if #(.N_CH(3), .W(4)) bus3 ();

    stream_mux_rr #(.N_CH(4), .W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    stream_mux_rr #(.N_CH(3), .W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int checks   = 0;
    int failures = 0;

    bit         m_valid;
    logic [3:0] m_data;
    int         m_ch;
    int         m_last;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_valid = 1'b0;
        m_data  = 4'h0;
        m_ch    = 0;
        m_last  = 3;
    endtask

    // Channel that wins this cycle under the arbitration rules, -1 when nobody wins.
    function automatic int modelGrant(input int last, input logic [3:0] valid,
                                      input logic md, input int s, input bit ld);
        if (!ld) return -1;
        if (md) return (s < 4 && valid[s]) ? s : -1;
        for (int k = 1; k <= 4; k++) begin
            if (valid[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic applyStimulus();
        int         g;
        bit         ld;
        logic [3:0] d;
        @(negedge clk);
        ld = !m_valid || bus.out_ready;
        g  = modelGrant(m_last, bus.in_valid, bus.mode, int'(bus.sel), ld);
        checkOutput("model_out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            checkOutput("model_out_data", bus.out_data, m_data);
            checkOutput("model_out_ch", bus.out_ch, m_ch);
        end
        checkOutput("model_in_ready", bus.in_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        d = (g >= 0) ? bus.in_data[g*4 +: 4] : 4'h0;
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d;
                m_ch    = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        int exp_rr[3];
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        bus3.in_valid  = 3'b111;
        bus3.in_data   = {4'h9, 4'h8, 4'h6};
        bus3.mode      = 1'b1;
        bus3.sel       = 2'd3;
        bus3.out_ready = 1'b1;
        modelReset();

        #12;
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_out_data", bus.out_data, 4'h0);
        checkOutput("rst_out_ch", bus.out_ch, 2'd0);
        checkOutput("rst_in_ready", bus.in_ready, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin fairness with all channels valid.
        bus.in_data   = {4'hd, 4'hc, 4'hb, 4'ha};
        bus.in_valid  = 4'hf;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("rr_ch", bus.out_ch, k % 4);
            checkOutput("rr_data", bus.out_data, 4'ha + (k % 4));
        end

        checkOutput("n3_sel3_ready", bus3.in_ready, 3'b000);
        checkOutput("n3_sel3_valid", bus3.out_valid, 1'b0);

        // Skip and wrap once channel 3 has been granted.
        bus.in_valid = 4'b1000;
        applyStimulus();
        checkOutput("wrap_ch3", bus.out_ch, 2'd3);
        bus.in_valid = 4'b1010;
        bus3.sel     = 2'd2;
        #1;
        checkOutput("n3_sel2_ready", bus3.in_ready, 3'b100);
        exp_rr = '{1, 3, 1};
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("skip_ch", bus.out_ch, exp_rr[k]);
        end
        checkOutput("n3_sel2_valid", bus3.out_valid, 1'b1);
        checkOutput("n3_sel2_ch", bus3.out_ch, 2'd2);
        checkOutput("n3_sel2_data", bus3.out_data, 4'h9);

        // Fixed select.
        bus.mode     = 1'b1;
        bus.sel      = 2'd2;
        bus.in_valid = 4'hf;
        #1;
        checkOutput("fix_ready", bus.in_ready, 4'b0100);
        applyStimulus();
        checkOutput("fix_data", bus.out_data, 4'hc);
        checkOutput("fix_ch", bus.out_ch, 2'd2);
        bus.in_valid = 4'b1011;
        applyStimulus();
        checkOutput("fix_novalid", bus.out_valid, 1'b0);

        // Backpressure holds the beat, release loads the next one with no bubble.
        bus.mode     = 1'b0;
        bus.in_data  = {4'h4, 4'h3, 4'h5, 4'h7};
        bus.in_valid = 4'b0001;
        applyStimulus();
        checkOutput("bp_load", bus.out_data, 4'h7);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hf;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("bp_hold_data", bus.out_data, 4'h7);
            checkOutput("bp_hold_ready", bus.in_ready, 4'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", bus.in_ready, 4'b0010);
        applyStimulus();
        checkOutput("bp_next_valid", bus.out_valid, 1'b1);
        checkOutput("bp_next_data", bus.out_data, 4'h5);
        checkOutput("bp_next_ch", bus.out_ch, 2'd1);

        // Reset in the middle of a transfer.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
        checkOutput("midrst_out_data", bus.out_data, 4'h0);
        checkOutput("midrst_out_ch", bus.out_ch, 2'd0);
        checkOutput("midrst_in_ready", bus.in_ready, 4'h0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus();
        checkOutput("midrst_first_ch", bus.out_ch, 2'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = 4'($urandom);
            bus.in_data   = 16'($urandom);
            bus.mode      = ($urandom_range(0, 3) == 0);
            bus.sel       = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
